// File: rtl/npc_trap_pkg.sv
// Shared types and constants for the NPC simulation-halt trap monitor.
package npc_trap_pkg;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned DRAIN_W = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_EBREAK  = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_TIMEOUT = 2'd2,
        CAUSE_NONE    = 2'd3
    } cause_e;

    localparam logic [INST_W-1:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [INST_W-1:0] INST_ZERO   = 32'h0000_0000;
    localparam logic [INST_W-1:0] INST_ONES   = 32'hFFFF_FFFF;

endpackage

// File: rtl/npc_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module npc_sat_counter #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/npc_trap_monitor.sv
// Simulation-halt monitor: detects ebreak/illegal/timeout, latches trap info, drains, then halts.
// Optional NPC_TRAP_DPI_EN: prints counters on entry to HALTED.
module npc_trap_monitor
    import npc_trap_pkg::*;
#(
    parameter int unsigned        XLEN         = 32,
    parameter int unsigned        CNT_W        = 64,
    parameter int unsigned        DRAIN_CYCLES = 2,
    parameter int unsigned        TIMEOUT      = 0,
    parameter logic [INST_W-1:0]  EBREAK_INST  = INST_EBREAK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    input  logic [INST_W-1:0] inst,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   a0,
    output logic              stall,
    output logic              halted,
    output logic [XLEN-1:0]   exit_code,
    output logic [XLEN-1:0]   trap_pc,
    output logic [1:0]        trap_cause,
    output logic              good_trap,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt
);

    localparam bit               TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_e               r_state, w_next_state;
    logic [DRAIN_W-1:0]   r_drain_cnt, w_drain_cnt_nxt;
    logic                 r_stall, r_halted, r_good_trap, w_good_trap_nxt;
    logic [XLEN-1:0]      r_exit_code, w_exit_code_nxt;
    logic [XLEN-1:0]      r_trap_pc, w_trap_pc_nxt;
    cause_e               r_trap_cause, w_trap_cause_nxt, w_cause;
    logic                 w_accept, w_trap;
    logic [CNT_W-1:0]     w_cycle_cnt, w_instret_cnt;

    assign w_accept = inst_valid && !r_stall && (r_state == RUN);

    // Trap source arbitration: ebreak beats illegal beats timeout.
    always_comb begin
        w_cause = CAUSE_NONE;
        if (w_accept && (inst == EBREAK_INST)) begin
            w_cause = CAUSE_EBREAK;
        end else if (w_accept && ((inst == INST_ZERO) || (inst == INST_ONES))) begin
            w_cause = CAUSE_ILLEGAL;
        end else if (TIMEOUT_EN && (r_state == RUN) && (w_cycle_cnt == TIMEOUT_LAST)) begin
            w_cause = CAUSE_TIMEOUT;
        end
    end

    assign w_trap = (w_cause != CAUSE_NONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= RUN;
            r_drain_cnt  <= '0;
            r_stall      <= 1'b0;
            r_halted     <= 1'b0;
            r_exit_code  <= '0;
            r_trap_pc    <= '0;
            r_trap_cause <= CAUSE_NONE;
            r_good_trap  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_drain_cnt  <= w_drain_cnt_nxt;
            r_stall      <= (w_next_state != RUN);
            r_halted     <= (w_next_state == HALTED);
            r_exit_code  <= w_exit_code_nxt;
            r_trap_pc    <= w_trap_pc_nxt;
            r_trap_cause <= w_trap_cause_nxt;
            r_good_trap  <= w_good_trap_nxt;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_drain_cnt_nxt  = r_drain_cnt;
        w_exit_code_nxt  = r_exit_code;
        w_trap_pc_nxt    = r_trap_pc;
        w_trap_cause_nxt = r_trap_cause;
        w_good_trap_nxt  = r_good_trap;
        case (r_state)
            RUN: begin
                if (w_trap) begin
                    w_next_state     = DRAIN;
                    w_drain_cnt_nxt  = DRAIN_W'(DRAIN_CYCLES - 1);
                    w_exit_code_nxt  = (w_cause == CAUSE_TIMEOUT) ? '1 : a0;
                    w_trap_pc_nxt    = pc;
                    w_trap_cause_nxt = w_cause;
                end
            end
            DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_next_state    = HALTED;
                    w_good_trap_nxt = (r_trap_cause == CAUSE_EBREAK) && (r_exit_code == '0);
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - DRAIN_W'(1);
                end
            end
            HALTED: begin
                w_next_state = HALTED;
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    npc_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (r_state != HALTED),
        .clr   (1'b0),
        .count (w_cycle_cnt)
    );

    npc_sat_counter #(.W(CNT_W)) u_instret_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (w_accept),
        .clr   (1'b0),
        .count (w_instret_cnt)
    );

`ifdef NPC_TRAP_DPI_EN
`ifndef SYNTHESIS
    // Report counters once, on the edge that enters HALTED.
    always @(posedge clk) begin
        if (rst && (r_state == DRAIN) && (w_next_state == HALTED)) begin
            $display("npc_trap_monitor: cycles=%0d instret=%0d", w_cycle_cnt, w_instret_cnt);
        end
    end
`endif
`else
    // Host polls halted; nothing extra to do here.
`endif

    assign stall       = r_stall;
    assign halted      = r_halted;
    assign exit_code   = r_exit_code;
    assign trap_pc     = r_trap_pc;
    assign trap_cause  = r_trap_cause;
    assign good_trap   = r_good_trap;
    assign cycle_cnt   = w_cycle_cnt;
    assign instret_cnt = w_instret_cnt;

endmodule

// File: tb/tb_npc_trap_monitor.sv
// Bench for npc_trap_monitor: three configurations share stimulus, each tracked by a trap-timeline model.
module tb_npc_trap_monitor;

    localparam int N = 3;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_valid = 1'b0;
    logic [31:0] inst = 32'h0;
    logic [31:0] pc = 32'h0;
    logic [31:0] a0 = 32'h0;

    logic        o_s [N];
    logic        o_h [N];
    logic        o_g [N];
    logic [31:0] o_e [N];
    logic [31:0] o_p [N];
    logic [1:0]  o_c [N];
    logic [63:0] o_cy[N];
    logic [63:0] o_ir[N];
    logic [4:0]  cy1, ir1;
    logic [2:0]  cy2, ir2;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    npc_trap_monitor dut0 (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .pc(pc), .a0(a0),
        .stall(o_s[0]), .halted(o_h[0]), .exit_code(o_e[0]), .trap_pc(o_p[0]),
        .trap_cause(o_c[0]), .good_trap(o_g[0]), .cycle_cnt(o_cy[0]), .instret_cnt(o_ir[0])
    );

    npc_trap_monitor #(.CNT_W(5), .TIMEOUT(20)) dut1 (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .pc(pc), .a0(a0),
        .stall(o_s[1]), .halted(o_h[1]), .exit_code(o_e[1]), .trap_pc(o_p[1]),
        .trap_cause(o_c[1]), .good_trap(o_g[1]), .cycle_cnt(cy1), .instret_cnt(ir1)
    );

    npc_trap_monitor #(.CNT_W(3), .DRAIN_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .pc(pc), .a0(a0),
        .stall(o_s[2]), .halted(o_h[2]), .exit_code(o_e[2]), .trap_pc(o_p[2]),
        .trap_cause(o_c[2]), .good_trap(o_g[2]), .cycle_cnt(cy2), .instret_cnt(ir2)
    );

    assign o_cy[1] = 64'(cy1);
    assign o_ir[1] = 64'(ir1);
    assign o_cy[2] = 64'(cy2);
    assign o_ir[2] = 64'(ir2);

    // Per-instance configuration
    function automatic int p_timeout(input int i);
        return (i == 1) ? 20 : 0;
    endfunction
    function automatic int p_drain(input int i);
        return (i == 2) ? 1 : 2;
    endfunction
    function automatic logic [63:0] p_max(input int i);
        return (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ((i == 1) ? 64'd31 : 64'd7);
    endfunction

    // Model: a trap happens at some edge; everything else is counted from that edge.
    bit          m_trap [N];
    int          m_since[N];
    logic [63:0] m_cyc  [N];
    logic [63:0] m_ir   [N];
    logic [31:0] m_exit [N];
    logic [31:0] m_pc   [N];
    logic [1:0]  m_cause[N];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_trap[i] = 1'b0; m_since[i] = 0; m_cyc[i] = 64'd0; m_ir[i] = 64'd0;
            m_exit[i] = 32'd0; m_pc[i] = 32'd0; m_cause[i] = 2'd3;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            if (!m_trap[i]) begin
                logic [1:0] c;
                c = 2'd3;
                if (inst_valid && inst == EBREAK) c = 2'd0;
                else if (inst_valid && (inst == 32'h0 || inst == 32'hFFFF_FFFF)) c = 2'd1;
                else if (p_timeout(i) != 0 && m_cyc[i] == 64'(p_timeout(i) - 1)) c = 2'd2;
                if (inst_valid && m_ir[i] != p_max(i)) m_ir[i] = m_ir[i] + 64'd1;
                if (m_cyc[i] != p_max(i)) m_cyc[i] = m_cyc[i] + 64'd1;
                if (c != 2'd3) begin
                    m_trap[i] = 1'b1; m_since[i] = 0; m_cause[i] = c; m_pc[i] = pc;
                    m_exit[i] = (c == 2'd2) ? 32'hFFFF_FFFF : a0;
                end
            end else if (m_since[i] < p_drain(i)) begin
                if (m_cyc[i] != p_max(i)) m_cyc[i] = m_cyc[i] + 64'd1;
                m_since[i]++;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT against its model on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    bit hm;
                    hm = m_trap[i] && (m_since[i] >= p_drain(i));
                    chk($sformatf("d%0d.stall", i), 64'(o_s[i]), 64'(m_trap[i]));
                    chk($sformatf("d%0d.halted", i), 64'(o_h[i]), 64'(hm));
                    chk($sformatf("d%0d.cause", i), 64'(o_c[i]), 64'(m_cause[i]));
                    chk($sformatf("d%0d.exit", i), 64'(o_e[i]), 64'(m_exit[i]));
                    chk($sformatf("d%0d.trap_pc", i), 64'(o_p[i]), 64'(m_pc[i]));
                    chk($sformatf("d%0d.cycle", i), o_cy[i], m_cyc[i]);
                    chk($sformatf("d%0d.instret", i), o_ir[i], m_ir[i]);
                    if (hm) chk($sformatf("d%0d.good", i), 64'(o_g[i]),
                                64'(m_cause[i] == 2'd0 && m_exit[i] == 32'd0));
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p, input logic [31:0] a);
        inst_valid = v; inst = ins; pc = p; a0 = a;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, NOP, 32'h0, 32'h0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".stall"}, 64'(o_s[0]), 64'd0);
        chk({tag, ".halted"}, 64'(o_h[0]), 64'd0);
        chk({tag, ".cause"}, 64'(o_c[0]), 64'd3);
        chk({tag, ".exit"}, 64'(o_e[0]), 64'd0);
        chk({tag, ".trap_pc"}, 64'(o_p[0]), 64'd0);
        chk({tag, ".good"}, 64'(o_g[0]), 64'd0);
        chk({tag, ".cycle"}, o_cy[0], 64'd0);
        chk({tag, ".instret"}, o_ir[0], 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0; inst_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Five addi then a good ebreak
        do_reset();
        for (int k = 0; k < 5; k++) drive(1'b1, NOP, 32'h8000_0000 + 32'(4 * k), 32'h0);
        drive(1'b1, EBREAK, 32'h8000_0014, 32'h0);
        chk("t1.stall", 64'(o_s[0]), 64'd1);
        chk("t1.halted_early", 64'(o_h[0]), 64'd0);
        chk("t1.instret", o_ir[0], 64'd6);
        idle(1);
        chk("t1.halted_mid", 64'(o_h[0]), 64'd0);
        idle(1);
        chk("t1.halted", 64'(o_h[0]), 64'd1);
        chk("t1.exit", 64'(o_e[0]), 64'd0);
        chk("t1.trap_pc", 64'(o_p[0]), 64'h8000_0014);
        chk("t1.cause", 64'(o_c[0]), 64'd0);
        chk("t1.good", 64'(o_g[0]), 64'd1);
        idle(3);
        chk("t1.hold_cycle", o_cy[0], 64'd8);

        // Bad trap: ebreak with nonzero a0
        do_reset();
        drive(1'b1, EBREAK, 32'h8000_0000, 32'h1);
        idle(2);
        chk("t2.halted", 64'(o_h[0]), 64'd1);
        chk("t2.exit", 64'(o_e[0]), 64'd1);
        chk("t2.good", 64'(o_g[0]), 64'd0);

        // Illegal all-zero; valid instructions during DRAIN are ignored
        do_reset();
        drive(1'b1, NOP, 32'h8000_0000, 32'h0);
        drive(1'b1, NOP, 32'h8000_0004, 32'h0);
        drive(1'b1, 32'h0, 32'h8000_0008, 32'h5);
        drive(1'b1, NOP, 32'h8000_000C, 32'h0);
        chk("t3.instret_drain", o_ir[0], 64'd3);
        drive(1'b1, EBREAK, 32'h8000_0010, 32'h0);
        chk("t3.halted", 64'(o_h[0]), 64'd1);
        chk("t3.cause", 64'(o_c[0]), 64'd1);
        chk("t3.trap_pc", 64'(o_p[0]), 64'h8000_0008);
        chk("t3.exit", 64'(o_e[0]), 64'd5);
        chk("t3.instret", o_ir[0], 64'd3);

        // Illegal all-ones
        do_reset();
        drive(1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
        idle(2);
        chk("t3b.cause", 64'(o_c[0]), 64'd1);
        chk("t3b.halted", 64'(o_h[0]), 64'd1);

        // Timeout on dut1; saturation on dut2
        do_reset();
        for (int k = 0; k < 25; k++) begin
            drive(1'b1, NOP, 32'h8000_0000 + 32'(4 * k), 32'h7);
            if (k == 18) chk("t4.stall_before", 64'(o_s[1]), 64'd0);
            if (k == 19) begin
                chk("t4.stall_at", 64'(o_s[1]), 64'd1);
                chk("t4.cause_at", 64'(o_c[1]), 64'd2);
            end
        end
        chk("t4.halted", 64'(o_h[1]), 64'd1);
        chk("t4.exit", 64'(o_e[1]), 64'hFFFF_FFFF);
        chk("t4.trap_pc", 64'(o_p[1]), 64'h8000_004C);
        chk("t4.cycle_hold", o_cy[1], 64'd22);
        chk("t4.instret", o_ir[1], 64'd20);
        chk("t4.d0_stall", 64'(o_s[0]), 64'd0);
        chk("t4.d0_cycle", o_cy[0], 64'd25);
        chk("t4.d0_instret", o_ir[0], 64'd25);
        chk("t4.sat_cycle", o_cy[2], 64'd7);
        chk("t4.sat_instret", o_ir[2], 64'd7);

        // Ebreak on the timeout cycle wins
        do_reset();
        for (int k = 0; k < 19; k++) drive(1'b1, NOP, 32'h8000_0000 + 32'(4 * k), 32'h0);
        drive(1'b1, EBREAK, 32'h8000_004C, 32'h0);
        idle(2);
        chk("t5.cause", 64'(o_c[1]), 64'd0);
        chk("t5.halted", 64'(o_h[1]), 64'd1);
        chk("t5.good", 64'(o_g[1]), 64'd1);
        chk("t5.exit", 64'(o_e[1]), 64'd0);

        // Asynchronous reset in DRAIN, then a clean halt
        do_reset();
        drive(1'b1, EBREAK, 32'h8000_0000, 32'h3);
        chk("t6.stall", 64'(o_s[0]), 64'd1);
        #2 rst = 1'b0;
        #1 chk_reset_vals("t6.async");
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, EBREAK, 32'h8000_0040, 32'h0);
        idle(2);
        chk("t6.halted", 64'(o_h[0]), 64'd1);
        chk("t6.good", 64'(o_g[0]), 64'd1);
        chk("t6.trap_pc", 64'(o_p[0]), 64'h8000_0040);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
